// File: rtl/wr_frame_addr_gen.sv
// ---------------------------------------------------------------------------
// wr_frame_addr_gen
//   Write-address generator for framebuffer writes into DRAM over a
//   valid/ready/last beat stream. It counts accepted beats within a frame and
//   presents the byte address of the pending beat with zero latency. It also
//   rotates across NUM_BUFS contiguous frame buffers and reports the most
//   recently completed buffer, burst starts and framing errors.
//
// Ports
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   enable_in            1: count handshakes, 0: ignore them
//   restart_in           synchronous return to beat 0 of buffer 0
//   valid_wr/rdy_wr      beat handshake
//   last_wr              beat is the last of its frame
//   err_clr_in           clear the sticky error flags
//   write_address_out    byte address of the pending beat
//   beat_idx_out         beat index within the current frame
//   wr_buf_out           buffer being written
//   rd_buf_out           most recently completed buffer
//   burst_first_out      pending beat starts a burst
//   frame_done_out       one-cycle pulse after a frame completes
//   short_frame_err_out  sticky: last_wr arrived before the final beat index
//   overrun_err_out      sticky: final beat index accepted without last_wr
// ---------------------------------------------------------------------------
module wr_frame_addr_gen #(
    parameter int                ADDR_W          = 27,
    parameter int                WORD_BYTES_LOG2 = 4,
    parameter int                FRAME_WORDS     = 115200,
    parameter int                BURST_LEN       = 16,
    parameter int                NUM_BUFS        = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    localparam int               CW              = $clog2(FRAME_WORDS),
    localparam int               BW              = $clog2(NUM_BUFS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    input  logic              restart_in,
    input  logic              valid_wr,
    input  logic              rdy_wr,
    input  logic              last_wr,
    input  logic              err_clr_in,
    output logic [ADDR_W-1:0] write_address_out,
    output logic [CW-1:0]     beat_idx_out,
    output logic [BW-1:0]     wr_buf_out,
    output logic [BW-1:0]     rd_buf_out,
    output logic              burst_first_out,
    output logic              frame_done_out,
    output logic              short_frame_err_out,
    output logic              overrun_err_out
);

    localparam logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(FRAME_WORDS) << WORD_BYTES_LOG2;
    localparam logic [CW-1:0]     LAST_IDX    = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0]     BURST_MASK  = CW'(BURST_LEN - 1);
    localparam logic [BW-1:0]     LAST_BUF    = BW'(NUM_BUFS - 1);
    localparam logic [BW-1:0]     RESET_RD    = BW'(NUM_BUFS - 1);

    logic [CW-1:0]     beat_idx_q, beat_idx_d;
    logic [BW-1:0]     wr_buf_q, wr_buf_d;
    logic [BW-1:0]     rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0] buf_base_q, buf_base_d;
    logic              frame_done_q, frame_done_d;
    logic              short_err_q, short_err_d;
    logic              overrun_err_q, overrun_err_d;

    logic hs;
    logic at_last;
    logic eof;
    logic short_set;
    logic overrun_set;

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hs      = enable_in & valid_wr & rdy_wr;
        at_last = (beat_idx_q == LAST_IDX);
        eof     = hs & (last_wr | at_last);

        // A restart discards the concurrent beat, including its error status.
        short_set   = eof & last_wr & ~at_last & ~restart_in;
        overrun_set = hs & at_last & ~last_wr & ~restart_in;

        beat_idx_d   = beat_idx_q;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        buf_base_d   = buf_base_q;
        frame_done_d = 1'b0;

        if (restart_in) begin
            beat_idx_d = '0;
            wr_buf_d   = '0;
            buf_base_d = BASE_ADDR;
        end else if (eof) begin
            beat_idx_d   = '0;
            rd_buf_d     = wr_buf_q;
            frame_done_d = 1'b1;
            // Base is stepped by addition so no multiplier is needed; the
            // buffer index decides the wrap so base never has to be compared.
            if (wr_buf_q == LAST_BUF) begin
                wr_buf_d   = '0;
                buf_base_d = BASE_ADDR;
            end else begin
                wr_buf_d   = wr_buf_q + BW'(1);
                buf_base_d = buf_base_q + FRAME_BYTES;
            end
        end else if (hs) begin
            beat_idx_d = beat_idx_q + CW'(1);
        end

        // Set wins over a simultaneous clear.
        short_err_d   = short_set   | (short_err_q   & ~err_clr_in);
        overrun_err_d = overrun_set | (overrun_err_q & ~err_clr_in);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            beat_idx_q    <= '0;
            wr_buf_q      <= '0;
            rd_buf_q      <= RESET_RD;
            buf_base_q    <= BASE_ADDR;
            frame_done_q  <= 1'b0;
            short_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            beat_idx_q    <= beat_idx_d;
            wr_buf_q      <= wr_buf_d;
            rd_buf_q      <= rd_buf_d;
            buf_base_q    <= buf_base_d;
            frame_done_q  <= frame_done_d;
            short_err_q   <= short_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Address and burst flag come straight from registers so they describe
    // the beat being presented in the same cycle.
    assign write_address_out   = buf_base_q + (ADDR_W'(beat_idx_q) << WORD_BYTES_LOG2);
    assign burst_first_out     = ((beat_idx_q & BURST_MASK) == '0);
    assign beat_idx_out        = beat_idx_q;
    assign wr_buf_out          = wr_buf_q;
    assign rd_buf_out          = rd_buf_q;
    assign frame_done_out      = frame_done_q;
    assign short_frame_err_out = short_err_q;
    assign overrun_err_out     = overrun_err_q;

endmodule
